// File: rtl/round_timer_ctrl.sv
// round_timer_ctrl: round sequencer for aux_timer; loads the round length, strobes ena_cnt once per
// TICK_CYCLES clocks, supports pause/restart, and turns tc into a one-cycle time_up event.
module round_timer_ctrl #(
  parameter int TICK_CYCLES = 31_500_000,
  parameter int WARN_SEC    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] level_sec,
  input  logic       tc,
  output logic       ena_cnt,
  output logic       loadN,
  output logic [7:0] data_in,
  output logic       time_up,
  output logic       running,
  output logic       paused,
  output logic [7:0] sec_left,
  output logic       warning
);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);
  localparam logic [7:0] WARN = 8'(WARN_SEC);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSED, EXPIRED} state_t;
  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          w_adv;
  // The prescaler only runs while the count is live, so a pause resumes mid-tick.
  assign w_adv = r_state == RUN && !pause && !tc;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_presc  <= '0;
      ena_cnt  <= 1'b0;
      data_in  <= '0;
      time_up  <= 1'b0;
      sec_left <= '0;
    end else if (start) begin
      r_state  <= LOAD;
      r_presc  <= '0;
      ena_cnt  <= 1'b0;
      data_in  <= level_sec;
      time_up  <= 1'b0;
      sec_left <= level_sec;
    end else begin
      r_presc  <= w_adv ? (r_presc == LAST ? '0 : r_presc + 1'b1) : r_presc;
      ena_cnt  <= w_adv && r_presc == LAST;
      sec_left <= (ena_cnt && sec_left != 0) ? sec_left - 1'b1 : sec_left;
      time_up  <= r_state == RUN && tc;
      r_state  <= r_state == LOAD ? RUN :
                  r_state == RUN ? (tc ? EXPIRED : pause ? PAUSED : RUN) :
                  (r_state == PAUSED && !pause) ? RUN : r_state;
    end
  end
  assign loadN   = r_state != LOAD;
  assign running = r_state == RUN || r_state == PAUSED;
  assign paused  = r_state == PAUSED;
  assign warning = running && sec_left != 0 && sec_left <= WARN;
endmodule
